// File: rtl/rom_loader.sv
// Streams a byte-wide hps_io BIN download into a 16-bit ROM write port, with an
// optional zero-fill of the ROM before each download and sticky error/word-count status.
module rom_loader #(
  parameter int unsigned ROM_WORDS      = 32768,
  parameter bit          CLEAR_ON_START = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [14:0] rom_wraddr,
  output logic [15:0] rom_data,
  output logic        rom_wren,
  output logic        cpu_hold,
  output logic [15:0] load_words,
  output logic        load_err
);

  localparam int unsigned AW  = 15;
  localparam int unsigned DW  = 16;
  localparam int unsigned BW  = 8;
  localparam int unsigned FAW = 24;
  localparam int unsigned CW  = 16;

  localparam logic [AW-1:0]  LAST_WORD  = AW'(ROM_WORDS - 1);
  localparam logic [FAW-1:0] WORD_LIMIT = FAW'(ROM_WORDS);
  localparam logic [CW-1:0]  WORDS_MAX  = CW'(32768);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_FLUSH
  } state_t;

  state_t         state, state_d;
  logic           dl_q, dl_arm;
  logic           dl_rise, dl_fall;
  logic           pending, pending_d;
  logic           pend_ok, pend_ok_d;
  logic [AW-1:0]  pend_addr, pend_addr_d;
  logic [BW-1:0]  hi_byte, hi_byte_d;
  logic           ioctl_wait_d;
  logic           rom_wren_d;
  logic [AW-1:0]  rom_wraddr_d;
  logic [DW-1:0]  rom_data_d;
  logic [CW-1:0]  load_words_d;
  logic           load_err_d;
  logic           wr_even, wr_odd, cur_in_range;

  // dl_arm blocks a phantom rising edge when download is still high as reset releases
  assign dl_rise      = ioctl_download & ~dl_q & dl_arm;
  assign dl_fall      = ~ioctl_download & dl_q;
  assign wr_even      = ioctl_wr & ~ioctl_addr[0];
  assign wr_odd       = ioctl_wr & ioctl_addr[0];
  assign cur_in_range = (ioctl_addr[24:1] < WORD_LIMIT);
  assign cpu_hold     = (state != ST_IDLE) | ioctl_download;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] n);
    return (n >= WORDS_MAX) ? n : n + CW'(1);
  endfunction

  // State and registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      dl_q       <= 1'b0;
      dl_arm     <= ~ioctl_download;
      pending    <= 1'b0;
      pend_ok    <= 1'b0;
      pend_addr  <= '0;
      hi_byte    <= '0;
      ioctl_wait <= 1'b0;
      rom_wren   <= 1'b0;
      rom_wraddr <= '0;
      rom_data   <= '0;
      load_words <= '0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_d;
      dl_q       <= ioctl_download;
      dl_arm     <= dl_arm | ~ioctl_download;
      pending    <= pending_d;
      pend_ok    <= pend_ok_d;
      pend_addr  <= pend_addr_d;
      hi_byte    <= hi_byte_d;
      ioctl_wait <= ioctl_wait_d;
      rom_wren   <= rom_wren_d;
      rom_wraddr <= rom_wraddr_d;
      rom_data   <= rom_data_d;
      load_words <= load_words_d;
      load_err   <= load_err_d;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d      = state;
    pending_d    = pending;
    pend_ok_d    = pend_ok;
    pend_addr_d  = pend_addr;
    hi_byte_d    = hi_byte;
    rom_wren_d   = 1'b0;
    rom_wraddr_d = rom_wraddr;
    rom_data_d   = rom_data;
    load_words_d = load_words;
    load_err_d   = load_err;

    unique case (state)
      ST_IDLE: begin
        if (dl_rise) begin
          load_words_d = '0;
          load_err_d   = 1'b0;
          pending_d    = 1'b0;
          if (CLEAR_ON_START) begin
            // First zero write leaves together with the state change
            state_d      = ST_CLEAR;
            rom_wren_d   = 1'b1;
            rom_wraddr_d = '0;
            rom_data_d   = '0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_CLEAR: begin
        if (dl_fall) begin
          state_d    = ST_IDLE;
          load_err_d = 1'b1;
        end else if (rom_wraddr == LAST_WORD) begin
          state_d = ST_LOAD;
        end else begin
          rom_wren_d   = 1'b1;
          rom_wraddr_d = rom_wraddr + AW'(1);
          rom_data_d   = '0;
        end
      end

      ST_LOAD: begin
        if (wr_even) begin
          hi_byte_d   = ioctl_dout;
          pend_addr_d = ioctl_addr[15:1];
          pend_ok_d   = cur_in_range;
          pending_d   = 1'b1;
        end else if (wr_odd) begin
          pending_d = 1'b0;
          if (cur_in_range) begin
            rom_wren_d   = 1'b1;
            rom_wraddr_d = ioctl_addr[15:1];
            rom_data_d   = {hi_byte, ioctl_dout};
            load_words_d = sat_inc(load_words);
          end else begin
            load_err_d = 1'b1;
          end
        end
        // A byte arriving with the falling edge is folded in before the flush decision
        if (dl_fall) begin
          if (pending_d) begin
            state_d    = ST_FLUSH;
            pending_d  = 1'b0;
            load_err_d = 1'b1;
            if (pend_ok_d) begin
              rom_wren_d   = 1'b1;
              rom_wraddr_d = pend_addr_d;
              rom_data_d   = {hi_byte_d, BW'(0)};
              load_words_d = sat_inc(load_words);
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_FLUSH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ioctl_wait_d = (state_d == ST_CLEAR);
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: two instances (clearing 8-word ROM, non-clearing 4-word ROM)
// share stimulus; a download-level model schedules the expected ROM writes and wait window per cycle.
module tb_rom_loader;

  localparam int MAXC = 2048;

  logic        clk_sys = 1'b0;
  logic        reset, ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        a_wait, a_wren, a_hold, a_err;
  logic [14:0] a_addr;
  logic [15:0] a_data, a_words;
  logic        b_wait, b_wren, b_hold, b_err;
  logic [14:0] b_addr;
  logic [15:0] b_data, b_words;

  logic        sel;
  logic        o_wait, o_wren, o_hold, o_err;
  logic [14:0] o_addr;
  logic [15:0] o_data, o_words;

  always #5 clk_sys = ~clk_sys;

  rom_loader #(.ROM_WORDS(8), .CLEAR_ON_START(1'b1)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(a_wait),
    .rom_wraddr(a_addr), .rom_data(a_data), .rom_wren(a_wren), .cpu_hold(a_hold),
    .load_words(a_words), .load_err(a_err));

  rom_loader #(.ROM_WORDS(4), .CLEAR_ON_START(1'b0)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(b_wait),
    .rom_wraddr(b_addr), .rom_data(b_data), .rom_wren(b_wren), .cpu_hold(b_hold),
    .load_words(b_words), .load_err(b_err));

  assign o_wait  = sel ? b_wait  : a_wait;
  assign o_wren  = sel ? b_wren  : a_wren;
  assign o_hold  = sel ? b_hold  : a_hold;
  assign o_err   = sel ? b_err   : a_err;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_data  = sel ? b_data  : a_data;
  assign o_words = sel ? b_words : a_words;

  int  cyc, total, passed, clr_seen;
  bit  chk_en;
  logic        exp_wren [MAXC];
  logic [14:0] exp_addr [MAXC];
  logic [15:0] exp_data [MAXC];
  logic        exp_wait [MAXC];
  logic [15:0] shadow [8];

  // Download-level model state
  int   m_cfg_words, m_load_from, m_pend_word, m_count;
  bit   m_cfg_clear, m_active, m_pend, m_err;
  logic [7:0] m_hi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic cycle_check();
    bit ok;
    ok = (o_wren === exp_wren[cyc]) && (o_wait === exp_wait[cyc]) &&
         (!exp_wren[cyc] || (o_addr === exp_addr[cyc] && o_data === exp_data[cyc]));
    total++;
    if (ok) passed++;
    else $display("FAIL cycle %0d: wren=%b addr=%h data=%h wait=%b, required wren=%b addr=%h data=%h wait=%b",
                  cyc, o_wren, o_addr, o_data, o_wait, exp_wren[cyc], exp_addr[cyc], exp_data[cyc], exp_wait[cyc]);
    if (o_wren === 1'b1 && o_addr < 15'd8) shadow[o_addr[2:0]] = o_data;
    if (o_wren === 1'b1 && o_wait === 1'b1 && o_data === 16'h0000) clr_seen++;
  endtask

  task automatic tick();
    @(negedge clk_sys);
    if (chk_en) cycle_check();
    @(posedge clk_sys);
    cyc++;
    #1;
    if (cyc >= MAXC - 16) begin
      $display("FAIL cycle_budget: got %0d cycles, required < %0d", cyc, MAXC - 16);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sched_write(input int c, input int w, input logic [15:0] d);
    exp_wren[c] = 1'b1;
    exp_addr[c] = 15'(w);
    exp_data[c] = d;
  endtask

  task automatic cancel_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_wren[i] = 1'b0;
      exp_wait[i] = 1'b0;
    end
  endtask

  function automatic int bump(input int n);
    return (n < 32768) ? n + 1 : n;
  endfunction

  task automatic clear_shadow();
    for (int i = 0; i < 8; i++) shadow[i] = 16'hDEAD;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cancel_from(cyc + 1);
    m_active = 1'b0; m_pend = 1'b0; m_count = 0; m_err = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_dl();
    int c = cyc;
    ioctl_download = 1'b1;
    m_count = 0; m_err = 1'b0; m_pend = 1'b0; m_active = 1'b1;
    if (m_cfg_clear) begin
      for (int k = 0; k < m_cfg_words; k++) begin
        sched_write(c + 1 + k, k, 16'h0000);
        exp_wait[c + 1 + k] = 1'b1;
      end
      m_load_from = c + 1 + m_cfg_words;
    end else begin
      m_load_from = c + 1;
    end
    tick();
  endtask

  task automatic model_fall(input int c);
    if (m_active) begin
      m_active = 1'b0;
      if (c < m_load_from) begin
        cancel_from(c + 1);
        m_err = 1'b1;
      end else if (m_pend) begin
        if (m_pend_word < m_cfg_words) begin
          sched_write(c + 1, m_pend_word, {m_hi, 8'h00});
          m_count = bump(m_count);
        end
        m_err  = 1'b1;
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    model_fall(cyc);
    tick();
  endtask

  task automatic send_byte(input int a, input logic [7:0] d, input bit fall);
    int c = cyc;
    int w = a / 2;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    if (fall) ioctl_download = 1'b0;
    if (m_active && c >= m_load_from) begin
      if (a % 2 == 0) begin
        m_hi = d; m_pend = 1'b1; m_pend_word = w;
      end else begin
        m_pend = 1'b0;
        if (w < m_cfg_words) begin
          sched_write(c + 1, w, {m_hi, d});
          m_count = bump(m_count);
        end else begin
          m_err = 1'b1;
        end
      end
    end
    if (fall) model_fall(c);
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_wait === 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk("wait_release", 32'(o_wait), 32'd0);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_words"}, 32'(o_words), 32'(m_count));
    chk({tag, "_err"},   32'(o_err),   32'(m_err));
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    sel = 1'b0; cyc = 0; total = 0; passed = 0; clr_seen = 0; chk_en = 1'b0;
    m_cfg_words = 8; m_cfg_clear = 1'b1; m_active = 1'b0; m_pend = 1'b0;
    m_count = 0; m_err = 1'b0; m_hi = '0; m_load_from = 0; m_pend_word = 0;
    for (int i = 0; i < MAXC; i++) begin
      exp_wren[i] = 1'b0; exp_addr[i] = '0; exp_data[i] = '0; exp_wait[i] = 1'b0;
    end
    clear_shadow();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_wren", 32'(o_wren), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_wait", 32'(o_wait), 32'd0);
    chk("rst_words", 32'(o_words), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_hold", 32'(o_hold), 32'd0);

    // Clearing download of 12 34 56 78
    start_dl();
    chk("clr_hold", 32'(o_hold), 32'd1);
    wait_ready();
    send_byte(0, 8'h12, 1'b0);
    send_byte(1, 8'h34, 1'b0);
    send_byte(2, 8'h56, 1'b0);
    send_byte(3, 8'h78, 1'b0);
    idle(2);
    end_dl();
    idle(3);
    check_status("even");
    chk("even_words_lit", 32'(o_words), 32'd2);
    chk("even_err_lit", 32'(o_err), 32'd0);
    chk("even_clears", 32'(clr_seen), 32'd8);
    chk("even_w0", 32'(shadow[0]), 32'h1234);
    chk("even_w1", 32'(shadow[1]), 32'h5678);
    for (int i = 2; i < 8; i++) chk("even_zeroed", 32'(shadow[i]), 32'd0);
    chk("even_hold_idle", 32'(o_hold), 32'd0);

    // Download dropped while clearing word 3
    start_dl();
    idle(3);
    end_dl();
    chk("abort_hold", 32'(o_hold), 32'd0);
    chk("abort_err_lit", 32'(o_err), 32'd1);
    idle(4);
    check_status("abort");

    // Reset with a pending byte and download still high, then a clean load
    start_dl();
    wait_ready();
    send_byte(0, 8'h12, 1'b0);
    do_reset();
    chk("mid_wren", 32'(o_wren), 32'd0);
    chk("mid_addr", 32'(o_addr), 32'd0);
    chk("mid_data", 32'(o_data), 32'd0);
    chk("mid_words", 32'(o_words), 32'd0);
    chk("mid_err", 32'(o_err), 32'd0);
    chk("mid_hold", 32'(o_hold), 32'd1);
    idle(4);
    end_dl();
    idle(2);
    start_dl();
    wait_ready();
    send_byte(0, 8'h9A, 1'b0);
    send_byte(1, 8'hBC, 1'b1);
    idle(3);
    check_status("coinc");
    chk("coinc_words_lit", 32'(o_words), 32'd1);
    chk("coinc_err_lit", 32'(o_err), 32'd0);
    chk("coinc_w0", 32'(shadow[0]), 32'h9ABC);
    chk("coinc_w1", 32'(shadow[1]), 32'd0);

    // Switch to the non-clearing 4-word instance
    sel = 1'b1;
    m_cfg_words = 4; m_cfg_clear = 1'b0;
    clear_shadow();
    do_reset();
    idle(1);

    // Odd-length file AB CD EF
    start_dl();
    wait_ready();
    send_byte(0, 8'hAB, 1'b0);
    send_byte(1, 8'hCD, 1'b0);
    send_byte(2, 8'hEF, 1'b0);
    chk("odd_hold", 32'(o_hold), 32'd1);
    end_dl();
    idle(3);
    check_status("odd");
    chk("odd_words_lit", 32'(o_words), 32'd2);
    chk("odd_err_lit", 32'(o_err), 32'd1);
    chk("odd_w0", 32'(shadow[0]), 32'hABCD);
    chk("odd_w1", 32'(shadow[1]), 32'hEF00);

    // 10-byte file into 4 words
    start_dl();
    wait_ready();
    for (int i = 0; i < 10; i++) send_byte(i, 8'(8'h10 + i), 1'b0);
    end_dl();
    idle(3);
    check_status("ovf");
    chk("ovf_words_lit", 32'(o_words), 32'd4);
    chk("ovf_err_lit", 32'(o_err), 32'd1);
    chk("ovf_w0", 32'(shadow[0]), 32'h1011);
    chk("ovf_w3", 32'(shadow[3]), 32'h1617);

    // Even byte arriving with the falling edge is flushed
    start_dl();
    wait_ready();
    send_byte(0, 8'h20, 1'b0);
    send_byte(1, 8'h21, 1'b0);
    send_byte(2, 8'h22, 1'b1);
    idle(3);
    check_status("flush");
    chk("flush_w1", 32'(shadow[1]), 32'h2200);
    chk("flush_words_lit", 32'(o_words), 32'd2);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ROM_WORDS, default 32768, sets the number of 16-bit ROM words; legal range 2..32768.
REQ-002 Parameter CLEAR_ON_START, default 1; when 1, the whole ROM is zeroed before each download is accepted.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset; driven from RESET/OSD reset only, never from ioctl_download.
REQ-005 ioctl_download  in  1  high for the duration of a BIN download from hps_io.
REQ-006 ioctl_wr  in  1  one-cycle strobe; ioctl_dout/ioctl_addr valid.
REQ-007 ioctl_addr  in  25  byte address within the file.
REQ-008 ioctl_dout  in  8  file byte.
REQ-009 ioctl_wait  out  1  stalls hps_io byte delivery.
REQ-010 rom_wraddr  out  15  ROM write word address.
REQ-011 rom_data  out  16  ROM write data.
REQ-012 rom_wren  out  1  ROM write enable, one-cycle pulses.
REQ-013 cpu_hold  out  1  holds CPU in reset while loading.
REQ-014 load_words  out  16  words written by the current/last download (0..32768).
REQ-015 load_err  out  1  sticky error: overflow, odd length, or aborted clear.

Function
REQ-016 States: IDLE, CLEAR, LOAD, FLUSH; ioctl_download is registered once (dl_q) and its edges are detected against dl_q.
REQ-017 IDLE: on rising edge of ioctl_download -> CLEAR if CLEAR_ON_START=1, else LOAD; load_words and load_err zeroed on that edge.
REQ-018 CLEAR: rom_wren=1, rom_data=0, rom_wraddr counts 0..ROM_WORDS-1 one per cycle; after writing ROM_WORDS-1 -> LOAD next cycle; clear does not increment load_words.
REQ-019 ioctl_wait=1 throughout CLEAR, 0 in every other state.
REQ-020 ioctl_wr while in CLEAR or IDLE is ignored (no write, no count).
REQ-021 LOAD, ioctl_wr with ioctl_addr[0]=0: latch ioctl_dout as high byte and ioctl_addr[15:1] as pending word address; set pending flag; no ROM write.
REQ-022 LOAD, ioctl_wr with ioctl_addr[0]=1: if ioctl_addr[24:1] < ROM_WORDS, write {high byte, ioctl_dout} to word ioctl_addr[15:1] with rom_wren high exactly on the cycle after the strobe (latency 1), increment load_words, clear pending.
REQ-023 Odd byte whose word address >= ROM_WORDS: no write, no count, load_err set; even bytes beyond range only latch.
REQ-024 Big-endian packing: even file byte -> rom_data[15:8], odd file byte -> rom_data[7:0].
REQ-025 Falling edge of ioctl_download in LOAD: if pending -> FLUSH, else -> IDLE.
REQ-026 FLUSH (one cycle): write {high byte, 8'h00} at pending address if in range, increment load_words, set load_err (odd length); -> IDLE.
REQ-027 ioctl_wr coincident with the falling edge of ioctl_download is processed before the pending decision of REQ-025.
REQ-028 Falling edge of ioctl_download during CLEAR: abort clear, set load_err, -> IDLE, ROM partially cleared.
REQ-029 cpu_hold = 1 when state != IDLE or ioctl_download = 1.
REQ-030 rom_wren is 0 in IDLE and whenever no write is defined above; at most one write per cycle.
REQ-031 load_words saturates at 32768; load_words and load_err hold their values in IDLE until the next download begins.

Reset
REQ-032 reset forces IDLE, pending=0, dl_q=0, rom_wren=0, rom_wraddr=0, rom_data=0, ioctl_wait=0, load_words=0, load_err=0; cpu_hold follows REQ-029.
REQ-033 reset mid-CLEAR or mid-LOAD aborts immediately with no further ROM writes; if ioctl_download is still high when reset releases, no new load starts until a fresh rising edge.

Verification
REQ-034 CLEAR_ON_START=1, ROM_WORDS=8, download of bytes 12 34 56 78 -> 8 zero writes at addr 0..7 with ioctl_wait=1, then 0x1234@0 and 0x5678@1; load_words=2, load_err=0.
REQ-035 CLEAR_ON_START=0, bytes AB CD EF, then ioctl_download falls -> 0xABCD@0, FLUSH writes 0xEF00@1; load_words=2, load_err=1.
REQ-036 ROM_WORDS=4, 10-byte file -> words 0..3 written, bytes 8-9 dropped; load_words=4, load_err=1.
REQ-037 ioctl_download falls during CLEAR at word 3 of 8 -> state IDLE, no further writes, load_err=1, cpu_hold=0 next cycle.
REQ-038 reset pulsed after byte 0x12 latched (pending) -> no FLUSH write, all outputs at REQ-032 values; a later rising edge of ioctl_download starts a clean load.
REQ-039 odd-byte strobe on the same cycle as ioctl_download falling, after an even byte 0x9A then odd byte 0xBC -> single write 0x9ABC, no FLUSH, load_err=0.
